aes128_iterative_core: RTL and testbench



---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_sbox.sv | 28 ++
 rtl/aes128_iterative_core.sv | 75 +++++++
 tb/tb_aes128_iterative_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round helpers.
// Internally the state is kept in FIPS byte order: byte k sits at bits [127-8k -: 8].
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  localparam int NUM_ROUNDS = 10;
  localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t mix_column(input word_t w);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  function automatic state_t shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
    return r;
  endfunction

  // Port lane i holds row i/4, column i%4, i.e. FIPS byte 4*(i%4)+i/4.
  function automatic state_t to_fips(input state_t p);
    state_t f;
    f = '0;
    for (int i = 0; i < 16; i++)
      f[127-8*(4*(i%4)+i/4) -: 8] = p[8*i +: 8];
    return f;
  endfunction

  function automatic state_t to_port(input state_t f);
    state_t p;
    p = '0;
    for (int i = 0; i < 16; i++)
      p[8*i +: 8] = f[127-8*(4*(i%4)+i/4) -: 8];
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, table lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes128_iterative_core.sv
// AES-128 encrypt core: one round per clock, round keys expanded alongside the data.
// Ports use row-major byte packing; internally everything is in FIPS byte order.
module aes128_iterative_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [127:0] CipherKey_i,
  input  logic [127:0] Data_i,
  output logic [127:0] AES_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [0:0] fsm;
  logic [3:0] round;
  state_t     state_q, rk_q;

  state_t sb_state, sr_state, next_rk, round_out, final_out;
  word_t  sw, w0n, w1n, w2n, w3n;
  logic [3:0] rcon_idx;
  byte_t      rcon;

  genvar g;
  for (g = 0; g < 16; g++) begin : g_sb_state
    aes_sbox u_sbox (.in_byte(state_q[8*g +: 8]), .out_byte(sb_state[8*g +: 8]));
  end
  for (g = 0; g < 4; g++) begin : g_sb_word
    aes_sbox u_sbox (.in_byte(rk_q[8*g +: 8]), .out_byte(sw[8*g +: 8]));
  end

  // SubWord commutes with RotWord, so rotate the substituted last word.
  assign rcon_idx = round - 4'd1;
  assign rcon     = RCON[rcon_idx];
  assign w0n      = rk_q[127:96] ^ {sw[23:0], sw[31:24]} ^ {rcon, 24'h0};
  assign w1n      = rk_q[95:64] ^ w0n;
  assign w2n      = rk_q[63:32] ^ w1n;
  assign w3n      = rk_q[31:0]  ^ w2n;
  assign next_rk  = {w0n, w1n, w2n, w3n};

  assign sr_state  = shift_rows(sb_state);
  assign round_out = mix_columns(sr_state) ^ next_rk;
  assign final_out = sr_state ^ next_rk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      round   <= '0;
      state_q <= '0;
      rk_q    <= '0;
      AES_o   <= '0;
    end else if (fsm == IDLE) begin
      if (en) begin
        state_q <= to_fips(Data_i ^ CipherKey_i);
        rk_q    <= to_fips(CipherKey_i);
        round   <= 4'd1;
        fsm     <= RUN;
      end
    end else if (en) begin
      rk_q <= next_rk;
      if (round == LAST_ROUND) begin
        AES_o <= to_port(final_out);
        round <= '0;
        fsm   <= IDLE;
      end else begin
        state_q <= round_out;
        round   <= round + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes128_iterative_core.sv
// Scoreboard bench: stimulus queues expected ciphertexts with their due cycle,
// a negedge monitor checks every cycle that AES_o holds or updates as expected.
module tb_aes128_iterative_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] data_in = '0;
  logic [127:0] aes_out;

  aes128_iterative_core dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .CipherKey_i(key_in), .Data_i(data_in), .AES_o(aes_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           due;
    logic [127:0] val;
  } exp_t;
  exp_t sbq[$];
  logic [127:0] hold = '0;
  logic [7:0]   sbt[256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: GF(2^8) arithmetic on byte arrays, FIPS-197 algorithm as written.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbt[x] = s;
    end
  endtask

  function automatic logic [127:0] fips_to_port(input logic [127:0] f);
    logic [127:0] p = '0;
    for (int i = 0; i < 16; i++)
      p[8*i +: 8] = f[127-8*(4*(i%4)+i/4) -: 8];
    return p;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] key_p, input logic [127:0] data_p);
    logic [7:0]  k[16];
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) begin
      k[4*(i%4)+i/4] = key_p[8*i +: 8];
      s[4*(i%4)+i/4] = data_p[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) w[i] = {k[4*i], k[4*i+1], k[4*i+2], k[4*i+3]};
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]};
        tmp ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] ^= w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      s = t;
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*rnd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[4*(i%4)+i/4];
    return o;
  endfunction

  // Monitor: at each negedge AES_o must equal the due result or the last one.
  always @(negedge rst_n) hold = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_result: due cyc %0d now %0d expected %h", sbq[0].due, cyc, sbq[0].val);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        hold = sbq[0].val;
        void'(sbq.pop_front());
        chk("result", aes_out, hold);
      end else begin
        chk("hold", aes_out, hold);
      end
    end
  end

  // Called right after a negedge; keeps en high for capture plus ten rounds.
  task automatic run_block(input logic [127:0] k, input logic [127:0] d, input logic [127:0] exp);
    key_in = k;
    data_in = d;
    en = 1'b1;
    sbq.push_back('{due: cyc + 11, val: exp});
    repeat (11) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  localparam logic [127:0] KEY_B  = 128'h3c88a6164f15d215cff7ae7e09ab282b;
  localparam logic [127:0] DATA_B = 128'h34a28da8079830f637315a43e0318832;
  localparam logic [127:0] EXP_B  = 128'h3297fb1d0b8509846a11dc2519dc0239;

  initial begin
    logic [127:0] key_c, data_c, exp_c, exp_z, rk, rd;
    build_sbox();
    key_c  = fips_to_port(128'h000102030405060708090a0b0c0d0e0f);
    data_c = fips_to_port(128'h00112233445566778899aabbccddeeff);
    exp_c  = fips_to_port(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    exp_z  = fips_to_port(128'h7df76b0c1ab899b33e42f047b91b546f);

    repeat (3) @(negedge clk);
    chk("reset_out", aes_out, '0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);   // en low: output stays zero, no capture

    run_block(KEY_B, DATA_B, EXP_B);
    run_block(key_c, data_c, exp_c);
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_block(rk, rd, model_enc(rk, rd));
    end

    // Stall: en low across five edges where round 4 would run.
    key_in = KEY_B;
    data_in = DATA_B;
    en = 1'b1;
    sbq.push_back('{due: cyc + 16, val: EXP_B});
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (7) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Data change mid-block; en held so the zero block is captured next.
    key_in = KEY_B;
    data_in = DATA_B;
    en = 1'b1;
    sbq.push_back('{due: cyc + 11, val: EXP_B});
    sbq.push_back('{due: cyc + 22, val: exp_z});
    repeat (3) @(negedge clk);
    data_in = '0;
    repeat (19) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-RUN with an asynchronous reset between edges.
    key_in = key_c;
    data_in = data_c;
    en = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", aes_out, '0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(key_c, data_c, exp_c);
    run_block(KEY_B, DATA_B, EXP_B);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
